irq_controller: RTL and testbench

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_pkg.sv | 23 ++
 rtl/irq_prio_enc.sv | 21 ++
 rtl/irq_controller.sv | 138 +++++++++++++
 tb/tb_irq_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets inside
// the 4-word window, FSM state encoding and the interrupt id width.
package irq_pkg;

  localparam int ID_W = 5;

  localparam logic [1:0] OFS_PENDING = 2'd0;
  localparam logic [1:0] OFS_MASK    = 2'd1;
  localparam logic [1:0] OFS_STATUS  = 2'd2;
  localparam logic [1:0] OFS_SWSET   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  // Absolute address of a register given the window base and its offset.
  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [1:0] ofs);
    return base + {30'd0, ofs};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: NUM_IRQ request vector to valid + id.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = 32
) (
  input  logic [NUM_IRQ-1:0] vec,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = |vec;
    idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: pending/mask registers, lowest-index arbitration and a
// non-nesting request/service handshake with the flow controller.
// Optional build macro IRQ_EDGE_DETECT_EN: pending bits set on 0->1 edges of
// irqIn instead of on every high cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no interrupt outstanding; arbitrates PENDING & MASK
// REQ     | irqReq high with irqId frozen, waiting for irqAck
// SERVICE | handler running, waiting for irqDone; new lines stay pending
module irq_controller
  import irq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int          NUM_IRQ   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irqIn,
  input  logic [31:0]        inputAddr,
  input  logic [31:0]        inputData,
  input  logic               wrEn,
  input  logic [31:0]        outputAddr,
  output logic [31:0]        outputData,
  output logic               irqReq,
  output logic [ID_W-1:0]    irqId,
  input  logic               irqAck,
  input  logic               irqDone
);

  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] hw_set;
  logic [NUM_IRQ-1:0] wr_data;
  irq_state_e         state_q;
  logic               irq_req_q;
  logic [ID_W-1:0]    irq_id_q;
  logic               enc_valid;
  logic [ID_W-1:0]    enc_idx;
  logic               wr_pending, wr_mask, wr_swset;
  logic               ack_take;

  assign wr_data    = inputData[NUM_IRQ-1:0];
  assign wr_pending = wrEn && (inputAddr == reg_addr(BASE_ADDR, OFS_PENDING));
  assign wr_mask    = wrEn && (inputAddr == reg_addr(BASE_ADDR, OFS_MASK));
  assign wr_swset   = wrEn && (inputAddr == reg_addr(BASE_ADDR, OFS_SWSET));
  assign ack_take   = (state_q == ST_REQ) && irqAck;

`ifdef IRQ_EDGE_DETECT_EN
  logic [NUM_IRQ-1:0] irq_prev_q;

  // Previous irqIn sample for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq_prev_q <= '0;
    else      irq_prev_q <= irqIn;
  end

  assign hw_set = irqIn & ~irq_prev_q;
`else
  assign hw_set = irqIn;
`endif

  // Next PENDING/MASK: clears applied first so any same-cycle set wins.
  always_comb begin
    pending_d = pending_q;
    if (wr_pending) pending_d = pending_d & ~wr_data;
    if (ack_take)   pending_d = pending_d & ~(NUM_IRQ'(1) << irq_id_q);
    pending_d = pending_d | hw_set;
    if (wr_swset)   pending_d = pending_d | wr_data;
    mask_d = wr_mask ? wr_data : mask_q;
  end

  // Register file state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
    .vec   (pending_q & mask_q),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  // Request/service FSM with registered irqReq and irqId.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      irq_req_q <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enc_valid) begin
            state_q   <= ST_REQ;
            irq_req_q <= 1'b1;
            irq_id_q  <= enc_idx;
          end
        end
        ST_REQ: begin
          if (irqAck) begin
            state_q   <= ST_SERVICE;
            irq_req_q <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (irqDone) state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          irq_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign irqReq = irq_req_q;
  assign irqId  = irq_id_q;

  // Combinational read port; anything outside the window reads zero.
  always_comb begin
    outputData = '0;
    if (outputAddr == reg_addr(BASE_ADDR, OFS_PENDING)) begin
      outputData[NUM_IRQ-1:0] = pending_q;
    end else if (outputAddr == reg_addr(BASE_ADDR, OFS_MASK)) begin
      outputData[NUM_IRQ-1:0] = mask_q;
    end else if (outputAddr == reg_addr(BASE_ADDR, OFS_STATUS)) begin
      outputData[1:0]  = state_q;
      outputData[12:8] = irq_id_q;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: table of per-cycle vectors plus
// hand-written sequences for reset, held-line and async-reset corner cases.
module tb_irq_controller;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] A_P  = BASE;
  localparam logic [31:0] A_M  = BASE + 32'd1;
  localparam logic [31:0] A_S  = BASE + 32'd2;
  localparam logic [31:0] A_W  = BASE + 32'd3;
`ifdef IRQ_EDGE_DETECT_EN
  localparam bit EDGE_MODE = 1'b1;
`else
  localparam bit EDGE_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] irqIn = '0;
  logic [31:0] inputAddr = '0;
  logic [31:0] inputData = '0;
  logic        wrEn = 1'b0;
  logic [31:0] outputAddr = '0;
  logic [31:0] outputData;
  logic        irqReq;
  logic [4:0]  irqId;
  logic        irqAck = 1'b0;
  logic        irqDone = 1'b0;

  irq_controller #(.BASE_ADDR(BASE), .NUM_IRQ(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .irqIn      (irqIn),
    .inputAddr  (inputAddr),
    .inputData  (inputData),
    .wrEn       (wrEn),
    .outputAddr (outputAddr),
    .outputData (outputData),
    .irqReq     (irqReq),
    .irqId      (irqId),
    .irqAck     (irqAck),
    .irqDone    (irqDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] irq;
    logic        ack;
    logic        done;
    logic [31:0] raddr;
    logic [31:0] exp_rd;
    logic        exp_req;
    logic [4:0]  exp_id;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic wr, logic [31:0] waddr, logic [31:0] wdata,
                              logic [31:0] irq, logic ack, logic done,
                              logic [31:0] raddr, logic [31:0] exp_rd,
                              logic exp_req, logic [4:0] exp_id);
    vec_t v;
    v.wr = wr; v.waddr = waddr; v.wdata = wdata; v.irq = irq;
    v.ack = ack; v.done = done; v.raddr = raddr; v.exp_rd = exp_rd;
    v.exp_req = exp_req; v.exp_id = exp_id;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [31:0] waddr, input logic [31:0] wdata,
                       input logic [31:0] irq, input logic ack, input logic done,
                       input logic [31:0] raddr);
    wrEn = wr; inputAddr = waddr; inputData = wdata; irqIn = irq;
    irqAck = ack; irqDone = done; outputAddr = raddr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic wr, input logic [31:0] waddr, input logic [31:0] wdata,
                      input logic [31:0] irq, input logic ack, input logic done,
                      input logic [31:0] raddr);
    drive(wr, waddr, wdata, irq, ack, done, raddr);
    tick();
  endtask

  initial begin
    int n;

    // ---------------- reset with all lines high
    drive(0, 0, 0, 32'hFFFF_FFFF, 0, 0, A_P);
    repeat (3) tick();
    check("rst_req", {31'd0, irqReq}, 32'd0);
    check("rst_id", {27'd0, irqId}, 32'd0);
    check("rst_pending", outputData, 32'd0);
    outputAddr = A_M; #1;
    check("rst_mask", outputData, 32'd0);
    outputAddr = A_S; #1;
    check("rst_status", outputData, 32'd0);
    rst = 1'b1;
    repeat (3) step(0, 0, 0, 32'hFFFF_FFFF, 0, 0, A_P);
    check("post_rst_req_masked", {31'd0, irqReq}, 32'd0);
    check("post_rst_pending", outputData, 32'hFFFF_FFFF);
    step(1, A_P, 32'hFFFF_FFFF, 0, 0, 0, A_P);
    check("post_rst_w1c", outputData, 32'd0);

    // ---------------- vector table: state observed after each edge
    // priority: bits 3 and 7 together
    tbl.push_back(mk(1, A_M, 32'hFFFF_FFFF, 0,     0, 0, A_M, 32'hFFFF_FFFF, 0, 0));
    tbl.push_back(mk(0, 0,   0,             32'h88, 0, 0, A_P, 32'h88,  0, 0));
    tbl.push_back(mk(0, 0,   0,             0,     0, 0, A_S, 32'h301, 1, 3));
    tbl.push_back(mk(0, 0,   0,             0,     1, 0, A_P, 32'h80,  0, 3));
    tbl.push_back(mk(0, 0,   0,             0,     1, 0, A_S, 32'h302, 0, 3));
    tbl.push_back(mk(0, 0,   0,             0,     0, 1, A_S, 32'h300, 0, 3));
    tbl.push_back(mk(0, 0,   0,             0,     0, 0, A_S, 32'h701, 1, 7));
    tbl.push_back(mk(0, 0,   0,             0,     0, 1, A_S, 32'h701, 1, 7));
    tbl.push_back(mk(1, A_M, 0,             0,     0, 0, A_S, 32'h701, 1, 7));
    tbl.push_back(mk(0, 0,   0,             0,     1, 0, A_P, 32'h0,   0, 7));
    tbl.push_back(mk(0, 0,   0,             0,     0, 1, A_S, 32'h700, 0, 7));
    // masking
    tbl.push_back(mk(1, A_M, 32'h2,         0,     0, 0, A_M, 32'h2,   0, 7));
    tbl.push_back(mk(0, 0,   0,             32'h1, 0, 0, A_P, 32'h1,   0, 7));
    tbl.push_back(mk(0, 0,   0,             0,     0, 0, A_P, 32'h1,   0, 7));
    tbl.push_back(mk(1, A_M, 32'h3,         0,     0, 0, A_M, 32'h3,   0, 7));
    tbl.push_back(mk(0, 0,   0,             0,     0, 0, A_S, 32'h001, 1, 0));
    tbl.push_back(mk(0, 0,   0,             0,     1, 0, A_P, 32'h0,   0, 0));
    tbl.push_back(mk(0, 0,   0,             0,     0, 1, A_S, 32'h000, 0, 0));
    // set/clear collision on bit 2 (masked off)
    tbl.push_back(mk(1, A_W, 32'h4,         0,     0, 0, A_P, 32'h4,   0, 0));
    tbl.push_back(mk(1, A_P, 32'h4,         32'h4, 0, 0, A_P, 32'h4,   0, 0));
    tbl.push_back(mk(1, A_P, 32'h4,         0,     0, 0, A_P, 32'h0,   0, 0));
    // SWSET
    tbl.push_back(mk(1, A_M, 32'h10,        0,     0, 0, A_M, 32'h10,  0, 0));
    tbl.push_back(mk(1, A_W, 32'h10,        0,     0, 0, A_W, 32'h0,   0, 0));
    tbl.push_back(mk(0, 0,   0,             0,     0, 0, A_S, 32'h401, 1, 4));
    tbl.push_back(mk(0, 0,   0,             0,     0, 0, A_P, 32'h10,  1, 4));
    tbl.push_back(mk(0, 0,   0,             0,     1, 0, A_P, 32'h0,   0, 4));
    tbl.push_back(mk(0, 0,   0,             0,     0, 1, A_S, 32'h400, 0, 4));
    // window edges and ignored writes
    tbl.push_back(mk(0, 0,   0,             0,     0, 0, BASE + 32'd4, 32'h0, 0, 4));
    tbl.push_back(mk(0, 0,   0,             0,     0, 0, BASE - 32'd1, 32'h0, 0, 4));
    tbl.push_back(mk(1, BASE + 32'd4, 32'hFFFF_FFFF, 0, 0, 0, A_M, 32'h10, 0, 4));
    tbl.push_back(mk(1, A_S, 32'hFFFF_FFFF, 0,     0, 0, A_P, 32'h0,   0, 4));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].wr, tbl[i].waddr, tbl[i].wdata, tbl[i].irq, tbl[i].ack,
           tbl[i].done, tbl[i].raddr);
      check($sformatf("vec%0d_rd", i), outputData, tbl[i].exp_rd);
      check($sformatf("vec%0d_req", i), {31'd0, irqReq}, {31'd0, tbl[i].exp_req});
      check($sformatf("vec%0d_id", i), {27'd0, irqId}, {27'd0, tbl[i].exp_id});
    end

    // ---------------- line 5 held high for 20 cycles, one ack/done
    step(1, A_M, 32'h20, 32'h20, 0, 0, A_P);
    n = 0;
    while (!irqReq && n < 4) begin
      step(0, 0, 0, 32'h20, 0, 0, A_P);
      n++;
    end
    check("held_first_req", {31'd0, irqReq}, 32'd1);
    check("held_first_id", {27'd0, irqId}, 32'd5);
    step(0, 0, 0, 32'h20, 1, 0, A_P);
    check("held_ack_pending", outputData, EDGE_MODE ? 32'h0 : 32'h20);
    repeat (14) step(0, 0, 0, 32'h20, 0, 0, A_P);
    step(0, 0, 0, 32'h20, 0, 1, A_P);
    step(0, 0, 0, 32'h20, 0, 0, A_P);
    step(0, 0, 0, 32'h20, 0, 0, A_P);
    check("held_second_req", {31'd0, irqReq}, EDGE_MODE ? 32'd0 : 32'd1);
    check("held_pending", outputData, EDGE_MODE ? 32'h0 : 32'h20);
    if (irqReq) begin
      step(0, 0, 0, 0, 1, 0, A_P);
      step(0, 0, 0, 0, 0, 1, A_P);
    end
    step(1, A_P, 32'hFFFF_FFFF, 0, 0, 0, A_S);
    check("held_cleanup_status", outputData & 32'h3, 32'h0);

    // ---------------- async reset while a request is outstanding
    step(1, A_M, 32'h1, 0, 0, 0, A_S);
    step(1, A_W, 32'h1, 0, 0, 0, A_S);
    step(0, 0, 0, 0, 0, 0, A_S);
    check("mid_req_status", outputData, 32'h001);
    check("mid_req_req", {31'd0, irqReq}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_req", {31'd0, irqReq}, 32'd0);
    check("async_rst_status", outputData, 32'h0);
    outputAddr = A_P; #1;
    check("async_rst_pending", outputData, 32'h0);
    tick();
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0, A_S);
    check("after_rst_idle", {31'd0, irqReq}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
